// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, clock mode constants and master FSM states.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_WAIT,
    ST_TRAIL,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter that measures one CLK_DIV-cycle phase and pulses
// expire in the last cycle of that phase.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       run_q, run_d;

  // A phase is armed by load and ends in the cycle the count reaches zero.
  assign expire = run_q && (cnt_q == 8'd0);

  // Next count: reload on a phase change, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = RELOAD;
      run_d = 1'b1;
    end else if (expire) begin
      run_d = 1'b0;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first. A one-byte holding register
// sits between the valid/ready stream and the shifter so consecutive bytes
// of one transaction go out with slave select held low.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_BYTE_W-1:0] tx_byte,
  input  logic                  tx_valid,
  input  logic                  tx_last,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_byte,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  spi_ss,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be in 2..255");
  end

  spi_state_e state_q, state_d;

  logic [SPI_BYTE_W-1:0] hold_byte_q, hold_byte_d;
  logic                  hold_last_q, hold_last_d;
  logic                  hold_full_q, hold_full_d;
  logic [SPI_BYTE_W-2:0] tx_sh_q, tx_sh_d;   // bits still to send after the one on mosi
  logic [SPI_BYTE_W-2:0] rx_sh_q, rx_sh_d;   // bits received so far in this byte
  logic                  cur_last_q, cur_last_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  spi_clk_q, spi_clk_d;
  logic                  spi_ss_q, spi_ss_d;
  logic                  spi_mosi_q, spi_mosi_d;
  logic [SPI_BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q, busy_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  miso_q;

  logic                  tmr_load;
  logic                  tmr_expire;
  logic                  load_sh;
  logic                  hs;
  logic                  byte_avail;
  logic [SPI_BYTE_W-1:0] next_byte;
  logic                  next_last;

  spi_half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .expire (tmr_expire)
  );

  assign tx_ready = tx_ready_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign spi_clk  = spi_clk_q;
  assign spi_ss   = spi_ss_q;
  assign spi_mosi = spi_mosi_q;

  // In IDLE/WAIT a byte arriving this cycle bypasses the empty holding register.
  assign hs         = tx_valid && tx_ready_q;
  assign byte_avail = hold_full_q || hs;
  assign next_byte  = hold_full_q ? hold_byte_q : tx_byte;
  assign next_last  = hold_full_q ? hold_last_q : tx_last;

  // Next-state, shifter, holding register and output computation.
  always_comb begin
    state_d     = state_q;
    hold_byte_d = hold_byte_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    cur_last_d  = cur_last_q;
    bit_cnt_d   = bit_cnt_q;
    spi_clk_d   = spi_clk_q;
    spi_ss_d    = spi_ss_q;
    spi_mosi_d  = spi_mosi_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    tmr_load    = 1'b0;
    load_sh     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_avail) begin
          load_sh   = 1'b1;
          spi_ss_d  = 1'b0;
          tmr_load  = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_expire) begin
          spi_clk_d = ~SPI_CPOL;
          tmr_load  = 1'b1;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // miso_q is captured in the last high cycle, right before the falling edge.
        if (tmr_expire) begin
          spi_clk_d = SPI_CPOL;
          tmr_load  = 1'b1;
          state_d   = ST_LOW;
          rx_sh_d   = {rx_sh_q[SPI_BYTE_W-3:0], miso_q};
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d  = {rx_sh_q, miso_q};
            rx_valid_d = 1'b1;
          end else begin
            spi_mosi_d = tx_sh_q[SPI_BYTE_W-2];
            tx_sh_d    = {tx_sh_q[SPI_BYTE_W-3:0], 1'b0};
          end
        end
      end
      ST_LOW: begin
        if (tmr_expire) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd7) begin
            spi_clk_d = ~SPI_CPOL;
            tmr_load  = 1'b1;
            state_d   = ST_HIGH;
          end else if (cur_last_q) begin
            tmr_load  = 1'b1;
            state_d   = ST_TRAIL;
          end else if (hold_full_q) begin
            load_sh   = 1'b1;
            tmr_load  = 1'b1;
            state_d   = ST_SETUP;
          end else begin
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (byte_avail) begin
          load_sh  = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_TRAIL: begin
        if (tmr_expire) begin
          spi_ss_d   = 1'b1;
          spi_mosi_d = 1'b0;
          tmr_load   = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_sh) begin
      spi_mosi_d = next_byte[SPI_BYTE_W-1];
      tx_sh_d    = next_byte[SPI_BYTE_W-2:0];
      cur_last_d = next_last;
    end

    // A bypassed byte never occupies the holding register.
    if (load_sh && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (hs && !load_sh) begin
      hold_full_d = 1'b1;
      hold_byte_d = tx_byte;
      hold_last_d = tx_last;
    end

    tx_ready_d = !hold_full_d;
    // busy falls one cycle after GAP returns to IDLE with nothing queued.
    busy_d     = hs || hold_full_q || (state_q != ST_IDLE);
  end

  // State and datapath registers; every output returns to its idle value on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_byte_q <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      cur_last_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      spi_clk_q   <= SPI_CPOL;
      spi_ss_q    <= 1'b1;
      spi_mosi_q  <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_byte_q <= hold_byte_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      cur_last_q  <= cur_last_d;
      bit_cnt_q   <= bit_cnt_d;
      spi_clk_q   <= spi_clk_d;
      spi_ss_q    <= spi_ss_d;
      spi_mosi_q  <= spi_mosi_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      tx_ready_q  <= tx_ready_d;
      miso_q      <= spi_miso;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a mode-0 slave model plus a bus monitor that checks
// every MOSI bit at rising SPI edges and every received byte against queues
// of accepted and returned bytes, with directed timing checks and random traffic.
module tb_spi_master;

  localparam int D  = 4;
  localparam int DB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] tx_byte;
  logic       tx_valid, tx_last, tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid, busy, spi_clk, spi_ss, spi_mosi, spi_miso;

  logic [7:0] txb_byte;
  logic       txb_valid, txb_last, txb_ready;
  logic [7:0] rxb_byte;
  logic       rxb_valid, busyb, spi_clkb, spi_ssb, spi_mosib, spi_misob;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_master #(.CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .tx_byte(txb_byte), .tx_valid(txb_valid), .tx_last(txb_last),
    .tx_ready(txb_ready), .rx_byte(rxb_byte), .rx_valid(rxb_valid), .busy(busyb),
    .spi_clk(spi_clkb), .spi_ss(spi_ssb), .spi_mosi(spi_mosib), .spi_miso(spi_misob)
  );

  assign spi_misob = spi_mosib;  // loopback

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model state ----------------
  logic [7:0] txq[$];       // accepted bytes not yet fully shifted out
  logic [7:0] exprx[$];     // bytes the slave returned, awaiting rx_valid
  logic [7:0] slave_q[$];   // forced slave responses (random when empty)
  logic [7:0] sl_byte;
  int         sl_cnt, rc;
  logic       miso_m;
  logic       prev_clk, prev_ss;
  int         rise_cnt, rx_cnt, ss_falls, ss_len, last_ss_len, busy_len, last_busy_len;
  int         last_hs_cyc;
  logic [31:0] rise_log;
  int         rise_cyc[$];
  int         rx_cyc[$];
  logic [7:0] last_rx;
  logic [7:0] rxb_q[$];
  int         rxb_cyc[$];

  assign spi_miso = miso_m;

  function automatic logic [7:0] next_resp();
    logic [7:0] r;
    if (slave_q.size() > 0) r = slave_q.pop_front();
    else r = 8'($urandom);
    return r;
  endfunction

  initial begin
    miso_m = 1'b0; prev_clk = 1'b0; prev_ss = 1'b1; sl_byte = 8'h00; sl_cnt = 0; rc = 0;
    rise_cnt = 0; rx_cnt = 0; ss_falls = 0; ss_len = 0; last_ss_len = 0;
    busy_len = 0; last_busy_len = 0; last_hs_cyc = 0; rise_log = 32'h0; last_rx = 8'h00;
  end

  // Monitor and slave model for the CLK_DIV=4 instance.
  always @(negedge clk) begin
    logic [7:0] cur;
    logic [7:0] e;
    if (rst) begin
      txq.delete(); exprx.delete();
      rc = 0; sl_cnt = 0; miso_m = 1'b0; ss_len = 0; busy_len = 0;
    end else begin
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_byte);
        last_hs_cyc = cyc;
      end
      if (prev_ss && !spi_ss) begin
        ss_falls++; ss_len = 0;
        sl_byte = next_resp(); sl_cnt = 0; miso_m = sl_byte[7];
      end
      if (!spi_ss) ss_len++;
      if (!prev_ss && spi_ss) last_ss_len = ss_len;
      if (busy) busy_len++;
      else if (busy_len != 0) begin last_busy_len = busy_len; busy_len = 0; end

      if (!prev_clk && spi_clk) begin
        rise_cnt++;
        rise_log = {rise_log[30:0], spi_mosi};
        rise_cyc.push_back(cyc);
        if (txq.size() == 0) begin
          chk("unexpected_spi_edge", 32'd1, 32'd0);
        end else begin
          cur = txq[0];
          chk("mosi_bit", {31'd0, spi_mosi}, {31'd0, cur[7-rc]});
          rc++;
          if (rc == 8) begin
            rc = 0;
            void'(txq.pop_front());
            exprx.push_back(sl_byte);
          end
        end
      end
      if (prev_clk && !spi_clk && !spi_ss) begin
        sl_cnt++;
        if (sl_cnt == 8) begin sl_cnt = 0; sl_byte = next_resp(); end
        miso_m = sl_byte[7-sl_cnt];
      end
      if (rx_valid) begin
        rx_cnt++; rx_cyc.push_back(cyc); last_rx = rx_byte;
        chk("rx_on_fall", {31'd0, (prev_clk && !spi_clk)}, 32'd1);
        if (exprx.size() == 0) chk("unexpected_rx_valid", 32'd1, 32'd0);
        else begin e = exprx.pop_front(); chk("rx_byte", {24'd0, rx_byte}, {24'd0, e}); end
      end
      if (spi_clk) chk("clk_high_needs_ss", {31'd0, spi_ss}, 32'd0);
      if (!spi_ss) chk("busy_during_ss", {31'd0, busy}, 32'd1);
    end
    prev_clk = spi_clk;
    prev_ss  = spi_ss;
  end

  // Receive log for the CLK_DIV=2 loopback instance.
  always @(negedge clk) begin
    if (!rst && rxb_valid) begin
      rxb_q.push_back(rxb_byte);
      rxb_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic [7:0] b, input logic l, input logic keep);
    int n = 0;
    tx_byte = b; tx_last = l; tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 3000) begin @(negedge clk); n++; end
    if (!tx_ready) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !tx_ready) && n < 5000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, br, f0, hs, n, sent;
    tx_byte = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
    txb_byte = 8'h00; txb_valid = 1'b0; txb_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss", {31'd0, spi_ss}, 32'd1);
    chk("rst_clk", {31'd0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_byte", {24'd0, rx_byte}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single byte 0xA5, slave returns 0x3C
    slave_q.push_back(8'h3C);
    b = rx_cnt; br = rise_cnt;
    send(8'hA5, 1'b1, 1'b0);
    hs = last_hs_cyc;
    wait_idle();
    chk("t1_rises", rise_cnt - br, 8);
    chk("t1_mosi_bits", {24'd0, rise_log[7:0]}, 32'hA5);
    chk("t1_rx_count", rx_cnt - b, 1);
    chk("t1_rx_byte", {24'd0, last_rx}, 32'h3C);
    chk("t1_ss_low_len", last_ss_len, 72);
    chk("t1_busy_len", last_busy_len, 77);
    if (rise_cyc.size() > br) chk("t1_first_edge_lead", rise_cyc[br] - hs, D + 1);

    // back-to-back 0x01 0x80 0xFF with valid held high
    b = rx_cnt; br = rise_cnt; f0 = ss_falls;
    send(8'h01, 1'b0, 1'b1);
    send(8'h80, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 1'b0);
    wait_idle();
    chk("t2_ss_falls", ss_falls - f0, 1);
    chk("t2_rises", rise_cnt - br, 24);
    chk("t2_mosi_bits", {8'd0, rise_log[23:0]}, 32'h0180FF);
    chk("t2_rx_count", rx_cnt - b, 3);
    chk("t2_ss_low_len", last_ss_len, 208);
    if (rx_cyc.size() >= b + 3) begin
      chk("t2_rx_space1", rx_cyc[b+1] - rx_cyc[b], 68);
      chk("t2_rx_space2", rx_cyc[b+2] - rx_cyc[b+1], 68);
    end

    // 0x55 without last, next byte 50 cycles after it completes
    b = rx_cnt; br = rise_cnt; f0 = ss_falls;
    send(8'h55, 1'b0, 1'b0);
    n = 0;
    while (rx_cnt == b && n < 1000) begin @(negedge clk); n++; end
    chk("t3_first_rx", rx_cnt - b, 1);
    repeat (50) @(posedge clk);
    #1;
    chk("t3_wait_ss", {31'd0, spi_ss}, 32'd0);
    chk("t3_wait_clk", {31'd0, spi_clk}, 32'd0);
    chk("t3_wait_no_edges", rise_cnt - br, 8);
    send(8'h0F, 1'b1, 1'b0);
    hs = last_hs_cyc;
    wait_idle();
    chk("t3_ss_falls", ss_falls - f0, 1);
    chk("t3_mosi_bits", {16'd0, rise_log[15:0]}, 32'h550F);
    if (rise_cyc.size() > br + 8) chk("t3_resume_lead", rise_cyc[br+8] - hs, D + 1);

    // backpressure: three bytes presented back to back during a transfer
    b = rx_cnt; br = rise_cnt;
    send(8'h11, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    send(8'h22, 1'b0, 1'b1);
    chk("t4_ready_drop", {31'd0, tx_ready}, 32'd0);
    send(8'h33, 1'b0, 1'b1);
    send(8'h44, 1'b1, 1'b0);
    wait_idle();
    chk("t4_rises", rise_cnt - br, 32);
    chk("t4_mosi_bits", rise_log, 32'h11223344);
    chk("t4_rx_count", rx_cnt - b, 4);

    // reset after three rising edges, then a clean 0xC3 transaction
    b = rx_cnt; br = rise_cnt;
    send(8'hF7, 1'b1, 1'b0);
    n = 0;
    while (rise_cnt < br + 3 && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    chk("t5_pre_clk", {31'd0, spi_clk}, 32'd1);
    chk("t5_pre_mosi", {31'd0, spi_mosi}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ss", {31'd0, spi_ss}, 32'd1);
    chk("t5_rst_clk", {31'd0, spi_clk}, 32'd0);
    chk("t5_rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("t5_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_no_rx", rx_cnt - b, 0);
    repeat (2) @(posedge clk);
    #1;
    slave_q.push_back(8'h5A);
    b = rx_cnt; br = rise_cnt;
    send(8'hC3, 1'b1, 1'b0);
    wait_idle();
    chk("t5_rises", rise_cnt - br, 8);
    chk("t5_mosi_bits", {24'd0, rise_log[7:0]}, 32'hC3);
    chk("t5_rx_count", rx_cnt - b, 1);
    chk("t5_rx_byte", {24'd0, last_rx}, 32'h5A);

    // random transactions with random inter-byte gaps
    b = rx_cnt; sent = 0;
    for (int t = 0; t < 12; t++) begin
      int len;
      len = int'($urandom_range(4, 1));
      for (int k = 0; k < len; k++) begin
        int gap;
        gap = ($urandom_range(3, 0) == 0) ? int'($urandom_range(90, 20)) : int'($urandom_range(3, 0));
        repeat (gap) @(posedge clk);
        #1;
        send(8'($urandom), (k == len - 1), 1'b0);
        sent++;
      end
      if ($urandom_range(1, 0) == 1) wait_idle();
    end
    wait_idle();
    chk("rand_rx_count", rx_cnt - b, sent);
    chk("rand_txq_empty", txq.size(), 0);
    chk("rand_exprx_empty", exprx.size(), 0);

    // CLK_DIV=2 loopback: 0x96 then 0x69
    txb_byte = 8'h96; txb_last = 1'b0; txb_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!txb_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    txb_byte = 8'h69; txb_last = 1'b1;
    n = 0;
    @(negedge clk);
    while (!txb_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    txb_valid = 1'b0;
    n = 0;
    while (rxb_q.size() < 2 && n < 2000) begin @(posedge clk); n++; end
    #1;
    chk("b_rx_count", rxb_q.size(), 2);
    if (rxb_q.size() >= 2) begin
      chk("b_rx_byte0", {24'd0, rxb_q[0]}, 32'h96);
      chk("b_rx_byte1", {24'd0, rxb_q[1]}, 32'h69);
      chk("b_byte_slot", rxb_cyc[1] - rxb_cyc[0], 34);
    end
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
